// File: rtl/sal_sched_pkg.sv
// Shared types and DFI pin encodings for the DDR2 command scheduler.
package sal_sched_pkg;

    typedef enum logic [1:0] {
        CMD_ACT = 2'd0,
        CMD_RD  = 2'd1,
        CMD_WR  = 2'd2,
        CMD_PRE = 2'd3
    } cmd_e;

    // Pin order is {cs_n, ras_n, cas_n, we_n}.
    localparam logic [3:0] DFI_ACT   = 4'b0011;
    localparam logic [3:0] DFI_RD    = 4'b0101;
    localparam logic [3:0] DFI_WR    = 4'b0100;
    localparam logic [3:0] DFI_PRE   = 4'b0010;
    localparam logic [3:0] DFI_NOP   = 4'b0111;
    localparam logic [3:0] DFI_DESEL = 4'b1111;

    localparam int unsigned A10_IDX = 10;

endpackage

// File: rtl/sal_rr_arbiter.sv
// Combinational round-robin pick: first request at or above the pointer, with wrap.
module sal_rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_idx
);

    always_comb begin
        logic          found;
        logic [PW-1:0] cand;
        o_gnt = '0;
        o_idx = '0;
        found = 1'b0;
        cand  = '0;
        // N is a power of two, so the PW-bit add wraps naturally.
        for (int k = 0; k < N; k++) begin
            cand = i_ptr + PW'(k);
            if (!found && i_req[cand]) begin
                found        = 1'b1;
                o_gnt[cand]  = 1'b1;
                o_idx        = cand;
            end
        end
    end

endmodule

// File: rtl/sal_cmd_sched.sv
// Per-bank DDR2 command scheduler: round-robin pick of timing-eligible requests,
// inter-bank tRRD/tCCD/tWTR/tRTW enforcement and registered DFI command drive.
module sal_cmd_sched
    import sal_sched_pkg::*;
#(
    parameter int unsigned BK_CNT = 4,
    parameter int unsigned BA_W   = $clog2(BK_CNT),
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned COL_W  = 10,
    parameter int unsigned TMR_W  = 5
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [BK_CNT-1:0]        i_req_valid,
    input  logic [2*BK_CNT-1:0]      i_req_cmd,
    input  logic [ADDR_W*BK_CNT-1:0] i_req_ra,
    input  logic [COL_W*BK_CNT-1:0]  i_req_ca,
    output logic [BK_CNT-1:0]        o_gnt,
    input  logic [TMR_W-1:0]         i_cfg_trrd,
    input  logic [TMR_W-1:0]         i_cfg_tccd,
    input  logic [TMR_W-1:0]         i_cfg_twtr,
    input  logic [TMR_W-1:0]         i_cfg_trtw,
    output logic                     o_dfi_cs_n,
    output logic                     o_dfi_ras_n,
    output logic                     o_dfi_cas_n,
    output logic                     o_dfi_we_n,
    output logic [BA_W-1:0]          o_dfi_bank,
    output logic [ADDR_W-1:0]        o_dfi_address,
    output logic                     o_rd_issue,
    output logic                     o_wr_issue
);

    // Saturating decrement; also turns a cfg value into its load value max(cfg-1, 0).
    function automatic logic [TMR_W-1:0] f_sat_dec(input logic [TMR_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    logic [TMR_W-1:0]  r_rrd_cnt, r_ccd_cnt, r_wtr_cnt, r_rtw_cnt;
    logic [BA_W-1:0]   r_ptr;
    logic [3:0]        r_pins;
    logic [BA_W-1:0]   r_bank;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rd_issue, r_wr_issue;

    logic [BK_CNT-1:0] w_elig;
    logic [BK_CNT-1:0] w_gnt;
    logic [BA_W-1:0]   w_idx;
    logic              w_any;
    cmd_e              w_cmd;
    logic [ADDR_W-1:0] w_ra, w_ca_ext;
    logic [3:0]        w_pins;
    logic [BA_W-1:0]   w_bank;
    logic [ADDR_W-1:0] w_addr;
    logic              w_rd_issue, w_wr_issue;

    always_comb begin
        cmd_e c;
        w_elig = '0;
        c      = CMD_ACT;
        for (int b = 0; b < BK_CNT; b++) begin
            c = cmd_e'(i_req_cmd[2*b +: 2]);
            unique case (c)
                CMD_ACT: w_elig[b] = i_req_valid[b] && (r_rrd_cnt == '0);
                CMD_RD:  w_elig[b] = i_req_valid[b] && (r_ccd_cnt == '0) && (r_wtr_cnt == '0);
                CMD_WR:  w_elig[b] = i_req_valid[b] && (r_ccd_cnt == '0) && (r_rtw_cnt == '0);
                CMD_PRE: w_elig[b] = i_req_valid[b];
                default: w_elig[b] = 1'b0;
            endcase
        end
        if (i_rst) begin
            w_elig = '0;
        end
    end

    sal_rr_arbiter #(
        .N  (BK_CNT),
        .PW (BA_W)
    ) u_arb (
        .i_req (w_elig),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    assign o_gnt    = w_gnt;
    assign w_any    = |w_gnt;
    assign w_cmd    = cmd_e'(i_req_cmd[{w_idx, 1'b0} +: 2]);
    assign w_ra     = i_req_ra[w_idx*ADDR_W +: ADDR_W];
    assign w_ca_ext = ADDR_W'(i_req_ca[w_idx*COL_W +: COL_W]);

    always_comb begin
        w_pins     = DFI_DESEL;
        w_bank     = r_bank;
        w_addr     = r_addr;
        w_rd_issue = 1'b0;
        w_wr_issue = 1'b0;
        if (w_any) begin
            w_bank = w_idx;
            unique case (w_cmd)
                CMD_ACT: begin
                    w_pins = DFI_ACT;
                    w_addr = w_ra;
                end
                CMD_RD: begin
                    w_pins     = DFI_RD;
                    w_addr     = w_ca_ext;
                    w_rd_issue = 1'b1;
                end
                CMD_WR: begin
                    w_pins     = DFI_WR;
                    w_addr     = w_ca_ext;
                    w_wr_issue = 1'b1;
                end
                CMD_PRE: begin
                    w_pins = DFI_PRE;
                    w_addr = '0;
                end
                default: w_pins = DFI_DESEL;
            endcase
            // No auto-precharge on RD/WR, single-bank PRE.
            if (w_cmd != CMD_ACT) begin
                w_addr[A10_IDX] = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rrd_cnt <= '0;
            r_ccd_cnt <= '0;
            r_wtr_cnt <= '0;
            r_rtw_cnt <= '0;
        end else begin
            r_rrd_cnt <= (w_any && w_cmd == CMD_ACT) ? f_sat_dec(i_cfg_trrd)
                                                     : f_sat_dec(r_rrd_cnt);
            r_ccd_cnt <= (w_any && (w_cmd == CMD_RD || w_cmd == CMD_WR)) ? f_sat_dec(i_cfg_tccd)
                                                                         : f_sat_dec(r_ccd_cnt);
            r_rtw_cnt <= (w_any && w_cmd == CMD_RD) ? f_sat_dec(i_cfg_trtw)
                                                    : f_sat_dec(r_rtw_cnt);
            r_wtr_cnt <= (w_any && w_cmd == CMD_WR) ? f_sat_dec(i_cfg_twtr)
                                                    : f_sat_dec(r_wtr_cnt);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr      <= '0;
            r_pins     <= DFI_DESEL;
            r_bank     <= '0;
            r_addr     <= '0;
            r_rd_issue <= 1'b0;
            r_wr_issue <= 1'b0;
        end else begin
            if (w_any) begin
                r_ptr <= w_idx + 1'b1;
            end
            r_pins     <= w_pins;
            r_bank     <= w_bank;
            r_addr     <= w_addr;
            r_rd_issue <= w_rd_issue;
            r_wr_issue <= w_wr_issue;
        end
    end

    assign o_dfi_cs_n    = r_pins[3];
    assign o_dfi_ras_n   = r_pins[2];
    assign o_dfi_cas_n   = r_pins[1];
    assign o_dfi_we_n    = r_pins[0];
    assign o_dfi_bank    = r_bank;
    assign o_dfi_address = r_addr;
    assign o_rd_issue    = r_rd_issue;
    assign o_wr_issue    = r_wr_issue;

endmodule
